// File: rtl/score_power_ctrl.sv
// Score, pellet and power-mode controller for the pacman game.
// Turns eat, ghost, tick and new-level strobes into the HUD score, the
// remaining-pellet count, the frightened-ghost power timer and the ghost
// combo award. All state lives in the VGA pixel clock domain.
module score_power_ctrl #(
    parameter int SCORE_W       = 20,
    parameter int CANDY_POINTS  = 10,
    parameter int COOKIE_POINTS = 50,
    parameter int GHOST_BASE    = 200,
    parameter int TOTAL_PELLETS = 244,
    parameter int POWER_TICKS   = 360,
    parameter int WARN_TICKS    = 120
) (
    input  logic               vga_pix_clk,
    input  logic               rst_n,
    input  logic               ate_candy_stb,
    input  logic               ate_power_cookie_stb,
    input  logic               ghost_eaten_stb,
    input  logic               tick_stb,
    input  logic               new_level_stb,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         pellets_left,
    output logic               power_mode,
    output logic               power_ending,
    output logic [10:0]        ghost_points,
    output logic               level_clear_stb
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_POWER  = 2'd1,
        ST_WARN   = 2'd2
    } state_e;

    localparam int TW = $clog2(POWER_TICKS + 1);
    // Wide enough that score plus the largest single-cycle gain cannot overflow.
    localparam int SUM_W = SCORE_W + 12;
    localparam logic [TW-1:0] POWER_T = TW'(POWER_TICKS);
    localparam logic [TW-1:0] WARN_T  = TW'(WARN_TICKS);
    localparam logic [7:0]    TOTAL_P = 8'(TOTAL_PELLETS);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [1:0]           combo_q, combo_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           pellets_q, pellets_d;
    logic [10:0]          ghost_q, ghost_d;
    logic                 clear_q, clear_d;
    logic                 pmode_q, pmode_d;
    logic                 pend_q, pend_d;

    logic                 active;
    logic                 has_pellets;
    logic                 candy_ok;
    logic                 cookie_ok;
    logic                 ghost_ok;
    logic [1:0]           combo_base;
    logic [1:0]           eat_cnt;
    logic [10:0]          award;
    logic [TW-1:0]        timer_dec;
    logic [SUM_W-1:0]     sum;

    // Next-state logic: new level wins, otherwise cookie reload beats tick,
    // and a ghost uses the combo as it stands after any cookie reset.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        combo_d     = combo_q;
        score_d     = score_q;
        pellets_d   = pellets_q;
        ghost_d     = ghost_q;
        clear_d     = 1'b0;

        active      = (state_q != ST_NORMAL);
        has_pellets = (pellets_q != 8'd0);
        candy_ok    = ate_candy_stb && has_pellets;
        cookie_ok   = ate_power_cookie_stb && has_pellets;
        eat_cnt     = {1'b0, candy_ok} + {1'b0, cookie_ok};
        combo_base  = cookie_ok ? 2'd0 : combo_q;
        ghost_ok    = ghost_eaten_stb && (active || cookie_ok);
        award       = ghost_ok ? 11'(GHOST_BASE << combo_base) : 11'd0;
        timer_dec   = timer_q - TW'(1);
        sum         = SUM_W'(score_q)
                    + (candy_ok  ? SUM_W'(CANDY_POINTS)  : SUM_W'(0))
                    + (cookie_ok ? SUM_W'(COOKIE_POINTS) : SUM_W'(0))
                    + SUM_W'(award);

        if (new_level_stb) begin
            pellets_d = TOTAL_P;
            state_d   = ST_NORMAL;
            timer_d   = '0;
            combo_d   = 2'd0;
        end else begin
            // Saturate rather than wrap when any bit above the score width is set.
            score_d   = (sum[SUM_W-1:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
            pellets_d = (pellets_q > {6'd0, eat_cnt}) ? pellets_q - {6'd0, eat_cnt} : 8'd0;
            clear_d   = has_pellets && (pellets_d == 8'd0);

            if (cookie_ok) begin
                state_d = ST_POWER;
                timer_d = POWER_T;
                combo_d = 2'd0;
                ghost_d = 11'd0;
            end

            if (ghost_ok) begin
                ghost_d = award;
                combo_d = (combo_base == 2'd3) ? 2'd3 : combo_base + 2'd1;
            end

            if (!cookie_ok && tick_stb && active) begin
                if (timer_q == TW'(1)) begin
                    state_d = ST_NORMAL;
                    timer_d = '0;
                    combo_d = 2'd0;
                end else begin
                    timer_d = timer_dec;
                    state_d = (timer_dec <= WARN_T) ? ST_WARN : ST_POWER;
                end
            end
        end

        pmode_d = (state_d != ST_NORMAL);
        pend_d  = (state_d == ST_WARN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_NORMAL;
            timer_q   <= '0;
            combo_q   <= 2'd0;
            score_q   <= '0;
            pellets_q <= TOTAL_P;
            ghost_q   <= 11'd0;
            clear_q   <= 1'b0;
            pmode_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            combo_q   <= combo_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
            ghost_q   <= ghost_d;
            clear_q   <= clear_d;
            pmode_q   <= pmode_d;
            pend_q    <= pend_d;
        end
    end

    assign score           = score_q;
    assign pellets_left    = pellets_q;
    assign power_mode      = pmode_q;
    assign power_ending    = pend_q;
    assign ghost_points    = ghost_q;
    assign level_clear_stb = clear_q;

endmodule

// File: tb/tb_score_power_ctrl.sv
// Bench for score_power_ctrl: directed scenario tasks plus a randomized run
// against a behavioural model of the scoring and power rules.
module tb_score_power_ctrl;

    localparam int TOTAL = 244;
    localparam int PT    = 360;
    localparam int WT    = 120;
    localparam int SMAX  = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        candy_stb, cookie_stb, ghost_stb, tick, newlvl;
    logic        candy8, zero8;
    logic [19:0] score;
    logic [7:0]  pellets;
    logic        pm, pe, lc;
    logic [10:0] gp;
    logic [7:0]  score8, pellets8;
    logic        pm8, pe8, lc8;
    logic [10:0] gp8;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_score, m_pellets, m_timer, m_combo, m_gp;
    bit m_power, m_clear;

    always #5 clk = ~clk;

    score_power_ctrl u_dut (
        .vga_pix_clk(clk), .rst_n(rst_n),
        .ate_candy_stb(candy_stb), .ate_power_cookie_stb(cookie_stb),
        .ghost_eaten_stb(ghost_stb), .tick_stb(tick), .new_level_stb(newlvl),
        .score(score), .pellets_left(pellets), .power_mode(pm),
        .power_ending(pe), .ghost_points(gp), .level_clear_stb(lc)
    );

    score_power_ctrl #(.SCORE_W(8)) u_dut8 (
        .vga_pix_clk(clk), .rst_n(rst_n),
        .ate_candy_stb(candy8), .ate_power_cookie_stb(zero8),
        .ghost_eaten_stb(zero8), .tick_stb(zero8), .new_level_stb(zero8),
        .score(score8), .pellets_left(pellets8), .power_mode(pm8),
        .power_ending(pe8), .ghost_points(gp8), .level_clear_stb(lc8)
    );

    task automatic model_reset();
        m_score = 0; m_pellets = TOTAL; m_timer = 0; m_combo = 0;
        m_gp = 0; m_power = 0; m_clear = 0;
    endtask

    task automatic model_step(input bit ci, input bit ki, input bit gi, input bit ti, input bit ni);
        int award;
        int oldp;
        bit cv, kv;
        award   = 0;
        m_clear = 0;
        if (ni) begin
            m_pellets = TOTAL; m_power = 0; m_timer = 0; m_combo = 0;
        end else begin
            oldp = m_pellets;
            cv = ci && (oldp > 0);
            kv = ki && (oldp > 0);
            if (kv) begin
                m_power = 1; m_timer = PT; m_combo = 0; m_gp = 0;
            end
            if (gi && m_power) begin
                award = 200 * (1 << m_combo);
                m_gp  = award;
                if (m_combo < 3) m_combo++;
            end
            if (!kv && ti && m_power) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_power = 0; m_combo = 0;
                end
            end
            m_pellets = oldp - int'(cv) - int'(kv);
            if (m_pellets < 0) m_pellets = 0;
            m_clear = (oldp > 0) && (m_pellets == 0);
            m_score = m_score + 10 * int'(cv) + 50 * int'(kv) + award;
            if (m_score > SMAX) m_score = SMAX;
        end
    endtask

    // One clock of stimulus on the main instance; the model follows the edge.
    task automatic drive(input bit ci, input bit ki, input bit gi, input bit ti, input bit ni);
        candy_stb = ci; cookie_stb = ki; ghost_stb = gi; tick = ti; newlvl = ni;
        @(posedge clk);
        model_step(ci, ki, gi, ti, ni);
        #1;
        candy_stb = 0; cookie_stb = 0; ghost_stb = 0; tick = 0; newlvl = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0;
        #20;
        n_checks++;
        if (score !== 20'd0 || pellets !== 8'd244 || pm !== 1'b0 || pe !== 1'b0 || gp !== 11'd0 || lc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state score=%0d pellets=%0d pm=%0b pe=%0b gp=%0d lc=%0b required 0/244/0/0/0/0",
                     score, pellets, pm, pe, gp, lc);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        $display("reset: score=%0d pellets=%0d", score, pellets);
    endtask

    task automatic test_candy();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++;
            if (score !== 20'(10 * (i + 1))) begin
                n_fail++;
                $display("FAIL candy_score[%0d] actual=%0d required=%0d", i, score, 10 * (i + 1));
            end
            for (int j = 0; j < 2; j++) begin
                drive(0, 0, 0, 0, 0);
                n_checks++;
                if (pm !== 1'b0) begin
                    n_fail++;
                    $display("FAIL candy_power_mode actual=%0b required=0", pm);
                end
            end
        end
        n_checks++;
        if (pellets !== 8'd241) begin
            n_fail++;
            $display("FAIL candy_pellets actual=%0d required=241", pellets);
        end
        $display("candy: score=%0d pellets=%0d", score, pellets);
    endtask

    task automatic test_cookie_ghost();
        int gexp[5] = '{200, 400, 800, 1600, 1600};
        int s0;
        s0 = int'(score);
        drive(0, 1, 0, 0, 0);
        n_checks++;
        if (score !== 20'(s0 + 50) || pm !== 1'b1 || pe !== 1'b0 || gp !== 11'd0) begin
            n_fail++;
            $display("FAIL cookie_entry score=%0d pm=%0b pe=%0b gp=%0d required %0d/1/0/0", score, pm, pe, gp, s0 + 50);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0);
            n_checks++;
            if (gp !== 11'(gexp[i])) begin
                n_fail++;
                $display("FAIL ghost_points[%0d] actual=%0d required=%0d", i, gp, gexp[i]);
            end
            drive(0, 0, 0, 0, 0);
        end
        n_checks++;
        if (score !== 20'(s0 + 50 + 4600)) begin
            n_fail++;
            $display("FAIL ghost_combo_score actual=%0d required=%0d", score, s0 + 4650);
        end
        $display("cookie_ghost: score=%0d gp=%0d", score, gp);
    endtask

    task automatic test_power_timeout();
        int s0;
        logic [10:0] g0;
        drive(0, 1, 0, 0, 0);
        for (int k = 1; k <= PT; k++) begin
            drive(0, 0, 0, 1, 0);
            if (k == 239 || k == 240) begin
                n_checks++;
                if (pe !== (k == 240) || pm !== 1'b1) begin
                    n_fail++;
                    $display("FAIL warn_edge tick=%0d pe=%0b pm=%0b required pe=%0b pm=1", k, pe, pm, k == 240);
                end
            end
            if (k == PT - 1 || k == PT) begin
                n_checks++;
                if (pm !== (k != PT) || pe !== (k != PT)) begin
                    n_fail++;
                    $display("FAIL power_end tick=%0d pm=%0b pe=%0b required %0b", k, pm, pe, k != PT);
                end
            end
        end
        s0 = int'(score);
        g0 = gp;
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (score !== 20'(s0) || gp !== g0) begin
            n_fail++;
            $display("FAIL ghost_in_normal score=%0d gp=%0d required %0d/%0d", score, gp, s0, g0);
        end
        $display("power_timeout: pm=%0b score=%0d", pm, score);
    endtask

    task automatic test_rearm();
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 300; k++) drive(0, 0, 0, 1, 0);
        n_checks++;
        if (pe !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_in_warn actual pe=%0b required=1", pe);
        end
        drive(0, 1, 0, 1, 0);
        n_checks++;
        if (pm !== 1'b1 || pe !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_reload pm=%0b pe=%0b required 1/0", pm, pe);
        end
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (gp !== 11'd200) begin
            n_fail++;
            $display("FAIL rearm_ghost actual=%0d required=200", gp);
        end
        for (int k = 0; k < 239; k++) drive(0, 0, 0, 1, 0);
        n_checks++;
        if (pe !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_timer_239 pe=%0b required=0", pe);
        end
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (pe !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_timer_240 pe=%0b required=1", pe);
        end
        $display("rearm: pm=%0b pe=%0b gp=%0d", pm, pe, gp);
    endtask

    task automatic test_level_clear();
        int clears;
        int s0;
        do_reset();
        clears = 0;
        drive(0, 1, 0, 0, 0);
        clears += int'(lc);
        for (int i = 0; i < 242; i++) begin
            drive(1, 0, 0, 0, 0);
            clears += int'(lc);
        end
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (lc !== 1'b1 || pellets !== 8'd0 || score !== 20'd2480) begin
            n_fail++;
            $display("FAIL last_pellet lc=%0b pellets=%0d score=%0d required 1/0/2480", lc, pellets, score);
        end
        clears += int'(lc);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            clears += int'(lc);
        end
        n_checks++;
        if (clears != 1) begin
            n_fail++;
            $display("FAIL level_clear_count actual=%0d required=1", clears);
        end
        s0 = int'(score);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        n_checks++;
        if (score !== 20'(s0) || pellets !== 8'd0 || lc !== 1'b0) begin
            n_fail++;
            $display("FAIL eat_when_empty score=%0d pellets=%0d lc=%0b required %0d/0/0", score, pellets, lc, s0);
        end
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (pellets !== 8'd244 || score !== 20'(s0) || pm !== 1'b0) begin
            n_fail++;
            $display("FAIL new_level pellets=%0d score=%0d pm=%0b required 244/%0d/0", pellets, score, pm, s0);
        end
        $display("level_clear: clears=%0d score=%0d pellets=%0d", clears, score, pellets);
    endtask

    task automatic test_random();
        logic [41:0] act_v, exp_v;
        bit ci, ki, gi, ti, ni;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ci = ($urandom_range(0, 2) == 0);
            ki = ($urandom_range(0, 19) == 0);
            gi = ($urandom_range(0, 5) == 0);
            ti = ($urandom_range(0, 2) == 0);
            ni = ($urandom_range(0, 149) == 0);
            drive(ci, ki, gi, ti, ni);
            act_v = {score, pellets, pm, pe, gp, lc};
            exp_v = {20'(m_score), 8'(m_pellets), m_power, m_power && (m_timer <= WT), 11'(m_gp), m_clear};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] actual score=%0d pel=%0d pm=%0b pe=%0b gp=%0d lc=%0b required score=%0d pel=%0d pm=%0b pe=%0b gp=%0d lc=%0b",
                         i, score, pellets, pm, pe, gp, lc, m_score, m_pellets, m_power,
                         m_power && (m_timer <= WT), m_gp, m_clear);
            end
        end
        $display("random: score=%0d pellets=%0d", score, pellets);
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 1; i <= 30; i++) begin
            candy8 = 1;
            @(posedge clk);
            #1;
            candy8 = 0;
            e = (10 * i > 255) ? 255 : 10 * i;
            n_checks++;
            if (score8 !== 8'(e)) begin
                n_fail++;
                $display("FAIL saturate[%0d] actual=%0d required=%0d", i, score8, e);
            end
        end
        $display("saturation: score8=%0d", score8);
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (pm !== 1'b1 || gp !== 11'd200) begin
            n_fail++;
            $display("FAIL pre_async pm=%0b gp=%0d required 1/200", pm, gp);
        end
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        n_checks++;
        if (score !== 20'd0 || pellets !== 8'd244 || pm !== 1'b0 || pe !== 1'b0 || gp !== 11'd0 || lc !== 1'b0
            || score8 !== 8'd0 || pellets8 !== 8'd244) begin
            n_fail++;
            $display("FAIL async_reset score=%0d pellets=%0d pm=%0b pe=%0b gp=%0d lc=%0b score8=%0d pellets8=%0d required 0/244/0/0/0/0/0/244",
                     score, pellets, pm, pe, gp, lc, score8, pellets8);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        $display("async_reset: score=%0d pellets=%0d", score, pellets);
    endtask

    initial begin
        candy_stb = 0; cookie_stb = 0; ghost_stb = 0; tick = 0; newlvl = 0;
        candy8 = 0; zero8 = 0;
        model_reset();
        test_reset();
        test_candy();
        test_cookie_ghost();
        test_power_timeout();
        test_rearm();
        test_level_clear();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
